// File: rtl/mem_port_arbiter_if.sv
// Request/grant/response bundle between the fetch and data requesters, the
// arbiter, and the single-port synchronous memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wren;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_funct3;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_data_in;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_data_out;

  // Arbiter view.
  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_wren, d_wdata, d_funct3, mem_data_out,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_address, mem_wren, mem_data_in, mem_funct3
  );

  // Requesters plus memory view.
  modport master (
    output f_req, f_addr, d_req, d_addr, d_wren, d_wdata, d_funct3, mem_data_out,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_address, mem_wren, mem_data_in, mem_funct3
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (data over fetch, with a fetch starvation guard) for a
// single synchronous memory port with one-cycle read latency.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [2:0]    FUNCT3_WORD = 3'b010;

  typedef enum logic {PORT_F = 1'b0, PORT_D = 1'b1} port_e;

  logic              f_sel_p0;
  logic              d_sel_p0;
  logic [ADDR_W-1:0] addr_p0;

  logic              vld_p1;
  port_e             port_p1;
  logic [SW-1:0]     d_streak;
  logic [ADDR_W-1:0] addr_p1;

  // Stage 0: grant decision and memory drive, same cycle as the request.
  // Grants are held off while reset is asserted so every output reads 0.
  always_comb begin
    f_sel_p0 = 1'b0;
    d_sel_p0 = 1'b0;
    if (reset) begin
      if (bus.d_req && (!bus.f_req || (d_streak < STREAK_MAX)))
        d_sel_p0 = 1'b1;
      else if (bus.f_req)
        f_sel_p0 = 1'b1;
    end
  end

  always_comb begin
    addr_p0         = addr_p1;
    bus.mem_funct3  = FUNCT3_WORD;
    bus.mem_wren    = 1'b0;
    bus.mem_data_in = '0;
    if (f_sel_p0) begin
      addr_p0 = bus.f_addr;
    end else if (d_sel_p0) begin
      addr_p0         = bus.d_addr;
      bus.mem_funct3  = bus.d_funct3;
      bus.mem_data_in = bus.d_wdata;
      bus.mem_wren    = bus.d_wren;
    end
  end

  assign bus.mem_address = addr_p0;
  assign bus.f_gnt       = f_sel_p0;
  assign bus.d_gnt       = d_sel_p0;

  // Stage 1: response tracking, aligned with the memory read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      port_p1  <= PORT_F;
      d_streak <= '0;
    end else begin
      vld_p1 <= f_sel_p0 | d_sel_p0;
      if (f_sel_p0 | d_sel_p0)
        port_p1 <= d_sel_p0 ? PORT_D : PORT_F;
      if (d_sel_p0 && bus.f_req)
        d_streak <= (d_streak == STREAK_MAX) ? d_streak : d_streak + SW'(1);
      else
        d_streak <= '0;
    end
  end

  // Idle cycles keep presenting the last granted address.
  always_ff @(posedge clk) begin
    if (f_sel_p0 | d_sel_p0)
      addr_p1 <= addr_p0;
  end

  assign bus.f_rvalid = vld_p1 && (port_p1 == PORT_F);
  assign bus.d_rvalid = vld_p1 && (port_p1 == PORT_D);
  assign bus.f_rdata  = bus.f_rvalid ? bus.mem_data_out : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.mem_data_out : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant checks at issue time, responses
// checked against a scoreboard of expected rvalid cycles and data.
module tb_mem_port_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int          due;
    logic        is_d;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_addr = '0;
  bit          addr_known = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd(logic [31:0] a);
    case (a)
      32'h0000_1000: rd = 32'h0050_0093;
      32'h0000_1004: rd = 32'h0010_0113;
      32'h0000_1008: rd = 32'h0020_81B3;
      default:       rd = {a[15:0] ^ 16'hC3C3, a[15:0]};
    endcase
  endfunction

  // Memory model: synchronous read, one cycle latency.
  always @(posedge clk) bus.mem_data_out <= rd(bus.mem_address);

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("rsp.f_rvalid", bus.f_rvalid, !e.is_d);
      chk("rsp.d_rvalid", bus.d_rvalid, e.is_d);
      if (e.is_d) begin
        if (e.chk_data) chk("rsp.d_rdata", bus.d_rdata, e.data);
        chk("rsp.f_rdata_zero", bus.f_rdata, 0);
      end else begin
        chk("rsp.f_rdata", bus.f_rdata, e.data);
        chk("rsp.d_rdata_zero", bus.d_rdata, 0);
      end
    end else begin
      chk("no_rsp.f_rvalid", bus.f_rvalid, 0);
      chk("no_rsp.d_rvalid", bus.d_rvalid, 0);
    end
  end

  task automatic drive(bit fr, logic [31:0] fa, bit dr, logic [31:0] da,
                       bit dw, logic [31:0] dd, logic [2:0] f3);
    bus.f_req    = fr;
    bus.f_addr   = fa;
    bus.d_req    = dr;
    bus.d_addr   = da;
    bus.d_wren   = dw;
    bus.d_wdata  = dd;
    bus.d_funct3 = f3;
  endtask

  task automatic step(string tag, bit ef, bit ed);
    @(negedge clk);
    chk({tag, ".f_gnt"}, bus.f_gnt, ef);
    chk({tag, ".d_gnt"}, bus.d_gnt, ed);
    chk({tag, ".one_gnt"}, bus.f_gnt & bus.d_gnt, 0);
    if (ef) begin
      chk({tag, ".addr"}, bus.mem_address, bus.f_addr);
      chk({tag, ".wren"}, bus.mem_wren, 0);
      chk({tag, ".funct3"}, bus.mem_funct3, 3'b010);
      sb.push_back('{due: cyc + 1, is_d: 1'b0, chk_data: 1'b1, data: rd(bus.f_addr)});
      last_addr  = bus.f_addr;
      addr_known = 1'b1;
    end else if (ed) begin
      chk({tag, ".addr"}, bus.mem_address, bus.d_addr);
      chk({tag, ".wren"}, bus.mem_wren, bus.d_wren);
      chk({tag, ".funct3"}, bus.mem_funct3, bus.d_funct3);
      if (bus.d_wren) chk({tag, ".wdata"}, bus.mem_data_in, bus.d_wdata);
      sb.push_back('{due: cyc + 1, is_d: 1'b1, chk_data: !bus.d_wren, data: rd(bus.d_addr)});
      last_addr  = bus.d_addr;
      addr_known = 1'b1;
    end else begin
      chk({tag, ".idle_wren"}, bus.mem_wren, 0);
      chk({tag, ".idle_funct3"}, bus.mem_funct3, 3'b010);
      if (addr_known) chk({tag, ".idle_addr"}, bus.mem_address, last_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    @(negedge clk);
    chk({tag, ".f_gnt"}, bus.f_gnt, 0);
    chk({tag, ".d_gnt"}, bus.d_gnt, 0);
    chk({tag, ".f_rvalid"}, bus.f_rvalid, 0);
    chk({tag, ".d_rvalid"}, bus.d_rvalid, 0);
    chk({tag, ".mem_wren"}, bus.mem_wren, 0);
    chk({tag, ".f_rdata"}, bus.f_rdata, 0);
    chk({tag, ".d_rdata"}, bus.d_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a fetch pending: nothing may be granted.
    drive(1, 32'h1000, 0, 0, 0, 0, 3'b010);
    repeat (2) @(posedge clk);
    chk_zero("rst_hold");
    @(posedge clk); #1;
    reset = 1'b1;
    step("fetch0", 1, 0);
    drive(0, 32'h1000, 0, 0, 0, 0, 3'b010);
    step("fetch0_rsp", 0, 0);

    // Store, then a load with a non-word funct3.
    drive(0, 32'h1000, 1, 32'h2004, 1, 32'hDEADBEEF, 3'b010);
    step("store", 0, 1);
    drive(0, 32'h1000, 0, 32'h2004, 0, 0, 3'b010);
    step("store_rsp", 0, 0);
    drive(0, 32'h1000, 1, 32'h3000, 0, 0, 3'b100);
    step("load", 0, 1);
    drive(0, 32'h1000, 0, 32'h3000, 0, 0, 3'b010);
    step("load_rsp", 0, 0);

    // Both requesting continuously: D,D,D,D,F repeating.
    drive(1, 32'h1000, 1, 32'h2000, 0, 0, 3'b010);
    for (int i = 0; i < 12; i++) step($sformatf("starve%0d", i), (i % 5) == 4, (i % 5) != 4);
    drive(0, 32'h1000, 0, 32'h2000, 0, 0, 3'b010);
    step("starve_drain", 0, 0);

    // Back-to-back fetch stream.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 3'b010);
      step($sformatf("stream%0d", i), 1, 0);
    end
    drive(0, 32'h1008, 0, 0, 0, 0, 3'b010);
    step("stream_drain0", 0, 0);
    step("stream_drain1", 0, 0);

    // Store request loses to fetch after the cap, then is withdrawn.
    drive(1, 32'h1004, 1, 32'h2100, 1, 32'hA5A5_0F0F, 3'b001);
    for (int i = 0; i < 4; i++) step($sformatf("cap_d%0d", i), 0, 1);
    step("cap_f", 1, 0);
    drive(0, 32'h1004, 0, 32'h2100, 1, 32'hA5A5_0F0F, 3'b001);
    step("withdrawn0", 0, 0);
    step("withdrawn1", 0, 0);

    // Reset right after a load grant drops its response.
    drive(0, 32'h1000, 1, 32'h3000, 0, 0, 3'b010);
    step("pre_rst_load", 0, 1);
    drive(0, 32'h1000, 0, 32'h3000, 0, 0, 3'b010);
    reset = 1'b0;
    sb.delete();
    addr_known = 1'b0;
    chk_zero("mid_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("post_rst%0d", i), 0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous `memory` access port between two requesters: instruction fetch (F) and load/store data (D).
- Sits between the `control`/datapath sequencing and the `memory` instance. Each requester gets a req/gnt/rvalid handshake, so the datapath no longer steers `adr_src` muxing by hand.
- Pipelined: one grant per cycle at most; each response returns exactly one cycle after its grant, matching the 1-cycle memory read latency.
- Fixed priority D > F, plus a starvation guard that forces F through after a bounded run of D grants.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, maximum consecutive D grants while F is pending (must be ≥ 1)

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request; held with f_addr stable until f_gnt
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  fetch read data valid (cycle after f_gnt)
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_addr/d_wren/d_wdata/d_funct3 stable until d_gnt
- d_addr  in  ADDR_W  data address
- d_wren  in  1  1 = store, 0 = load
- d_wdata  in  DATA_W  store data
- d_funct3  in  3  access size/sign, passed to memory
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  data access complete (load data valid or store done), cycle after d_gnt
- d_rdata  out  DATA_W  load data
- mem_address  out  ADDR_W  to memory address port
- mem_wren  out  1  to memory write enable
- mem_data_in  out  DATA_W  to memory write data
- mem_funct3  out  3  to memory funct3
- mem_data_out  in  DATA_W  from memory, valid one cycle after address

Behaviour:
- Reset (reset=0, async) clears state:
  - resp_valid=0, resp_port=F, d_streak=0.
  - All outputs 0: f_gnt, d_gnt, f_rvalid, d_rvalid, mem_wren.
  - f_rdata, d_rdata = 0.
- Grant (combinational, same cycle as req):
  - Only D pending: grant D.
  - Only F pending: grant F.
  - Both pending: grant D if d_streak < MAX_D_STREAK, else grant F.
  - Neither pending: no grant.
  - At most one of f_gnt/d_gnt is high in any cycle.
- Memory drive follows the granted port:
  - F granted: mem_address=f_addr, mem_funct3=3'b010, mem_wren=0.
  - D granted: mem_address=d_addr, mem_funct3=d_funct3, mem_data_in=d_wdata, mem_wren=d_wren.
  - No grant: mem_wren=0; mem_address holds the last granted address (register it); mem_funct3=3'b010.
- Response pipeline:
  - On a grant, resp_valid<=1 and resp_port<=granted port; with no grant, resp_valid<=0.
  - Next cycle: f_rvalid=resp_valid&&resp_port==F, d_rvalid=resp_valid&&resp_port==D.
  - The matching rdata=mem_data_out; the non-selected rdata=0.
  - d_rvalid pulses for stores too; d_rdata is don't-care on store completion.
- Back-to-back: grants are allowed in consecutive cycles. The response for grant N and the issue of grant N+1 occur in the same cycle.
- Starvation counter d_streak:
  - D granted while f_req=1: d_streak<=d_streak+1, saturating at MAX_D_STREAK.
  - F granted, or f_req=0: d_streak<=0.
- Requester obligations:
  - Deasserting req before gnt is allowed: the request is withdrawn and no response is produced.
  - A requester may re-assert req in the cycle of its own rvalid.
- Reset mid-transaction: any in-flight response is dropped. No rvalid is asserted after reset release until a new grant occurs.
- No combinational path from mem_data_out to any gnt.

Test Plan:
- Reset hold, then release with f_req=1, f_addr=0x1000 → f_gnt=1 in that cycle, mem_address=0x1000, mem_wren=0. Next cycle f_rvalid=1 and f_rdata=mem_data_out (model returns 0x00500093).
- d_req=1, d_wren=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_funct3=3'b010, f_req=0 → d_gnt=1 and mem_wren=1 with those values. Next cycle d_rvalid=1, f_rvalid=0.
- f_req and d_req both held high for 12 cycles, MAX_D_STREAK=4 → grant sequence D,D,D,D,F,D,D,D,D,F,D,D. Never both gnt high.
- Fetch every cycle at 0x1000,0x1004,0x1008 → a grant each cycle. f_rvalid high for 3 consecutive cycles, each delayed one cycle, with data matching address order.
- d_req asserted, then deasserted before gnt (F holding priority after the streak cap) → no d_gnt, no d_rvalid, no mem_wren.
- reset asserted in the cycle after a D load grant → d_rvalid stays 0, all outputs 0. After release with no req, mem_wren=0 and no rvalid for ≥3 cycles.
